// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg -- shared definitions for the AES control sequencer.
//   state_e        : sequencer FSM states
//   CTRL_*         : bit positions inside the HPS control byte (ctrl_in)
//   STAT_*         : bit positions inside the status byte (status_out)
package aes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

  localparam int CTRL_START   = 0;
  localparam int CTRL_DECRYPT = 1;
  localparam int CTRL_SOFT_RST = 2;
  localparam int CTRL_IRQ_CLR = 3;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_TIMEOUT   = 2;
  localparam int STAT_DECRYPT   = 3;
  localparam int STAT_OPCNT_LSB = 4;

endpackage

// File: rtl/aes_ctrl_sync.sv
// aes_ctrl_sync -- multi-flop synchronizer for the HPS control byte.
//   clk, reset_n : clock, asynchronous active-low reset
//   din          : asynchronous input bus
//   dout         : synchronized bus (STAGES flops deep)
//   dout_valid   : 1 once a real input sample has reached dout after reset,
//                  so reset-filler zeros can be told apart from a sampled 0
module aes_ctrl_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [STAGES-1:0]            fill_q, fill_d;

  always_comb begin
    sync_d    = sync_q;
    fill_d    = fill_q;
    sync_d[0] = din;
    fill_d[0] = 1'b1;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
      fill_d[i] = fill_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= sync_d;
      fill_q <= fill_d;
    end
  end

  assign dout       = sync_q[STAGES-1];
  assign dout_valid = fill_q[STAGES-1];

endmodule

// File: rtl/aes_ctrl_seq.sv
// aes_ctrl_seq -- AES core control sequencer driven by an HPS PIO byte.
//   clk, reset_n  : clock, asynchronous active-low reset
//   ctrl_in[7:0]  : [0] START (rising edge), [1] DECRYPT, [2] SOFT_RST, [3] IRQ_CLR
//   core_done     : completion pulse from the AES core (honoured only in WAIT)
//   core_start    : one-cycle start pulse to the core
//   core_decrypt  : mode latched at start
//   core_abort    : one-cycle abort pulse (soft reset out of ISSUE/WAIT, or timeout)
//   status_out    : {op_count[3:0], core_decrypt, timeout, done, busy}
//   irq           : done sticky OR timeout sticky
//   dbg_state     : current FSM state (aes_ctrl_pkg::state_e encoding)
// Optional feature: define AES_CTRL_TIMEOUT_EN to enable the WAIT watchdog.
//
// Handshake: core_start is a single-cycle strobe with no back-pressure;
// core_done is a single-cycle strobe accepted only while in WAIT.
module aes_ctrl_seq
  import aes_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ctrl_in,
  input  logic       core_done,
  output logic       core_start,
  output logic       core_decrypt,
  output logic       core_abort,
  output logic [7:0] status_out,
  output logic       irq,
  output logic [2:0] dbg_state
);

  logic [7:0] ctrl_sync;
  logic       ctrl_valid;

  aes_ctrl_sync #(.STAGES(SYNC_STAGES), .WIDTH(8)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (ctrl_in),
    .dout       (ctrl_sync),
    .dout_valid (ctrl_valid)
  );

  state_e      state_q, state_d;
  logic        start_prev_q, start_prev_d;
  logic        start_arm_q, start_arm_d;
  logic        decrypt_q, decrypt_d;
  logic [15:0] op_count_q, op_count_d;
  logic        done_q, done_d;
  logic        tmo_q, tmo_d;
  logic        start_q, start_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;
  logic        irq_q, irq_d;
`ifdef AES_CTRL_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
`endif

  logic soft_rst, irq_clr, start_edge;

  assign soft_rst = ctrl_sync[CTRL_SOFT_RST];
  assign irq_clr  = ctrl_sync[CTRL_IRQ_CLR];
  // The edge detector is armed only after a genuinely sampled START=0, so a
  // START already held high across reset never looks like a fresh edge.
  assign start_edge = start_arm_q & ctrl_sync[CTRL_START] & ~start_prev_q & ~soft_rst;

  always_comb begin
    state_d      = state_q;
    start_prev_d = ctrl_sync[CTRL_START];
    start_arm_d  = start_arm_q | (ctrl_valid & ~ctrl_sync[CTRL_START]);
    decrypt_d    = decrypt_q;
    op_count_d   = op_count_q;
    done_d       = done_q;
    tmo_d        = tmo_q;
    abort_d      = 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    // Clear first so a set event later in this block wins.
    if (irq_clr) begin
      done_d = 1'b0;
      tmo_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_ISSUE;
          decrypt_d = ctrl_sync[CTRL_DECRYPT];
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef AES_CTRL_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      ST_WAIT: begin
        if (core_done) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          op_count_d = op_count_q + 16'd1;
        end
`ifdef AES_CTRL_TIMEOUT_EN
        // cnt_q counts completed WAIT cycles; this is the last allowed one.
        else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ERROR;
          abort_d = 1'b1;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (soft_rst) begin
      state_d    = ST_IDLE;
      done_d     = 1'b0;
      tmo_d      = 1'b0;
      op_count_d = op_count_q;
      decrypt_d  = decrypt_q;
      abort_d    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    end

    start_d = (state_d == ST_ISSUE);
    busy_d  = (state_d != ST_IDLE);
    irq_d   = done_d | tmo_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      start_prev_q <= 1'b0;
      start_arm_q  <= 1'b0;
      decrypt_q    <= 1'b0;
      op_count_q   <= '0;
      done_q       <= 1'b0;
      tmo_q        <= 1'b0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      busy_q       <= 1'b0;
      irq_q        <= 1'b0;
`ifdef AES_CTRL_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      start_arm_q  <= start_arm_d;
      decrypt_q    <= decrypt_d;
      op_count_q   <= op_count_d;
      done_q       <= done_d;
      tmo_q        <= tmo_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      busy_q       <= busy_d;
      irq_q        <= irq_d;
`ifdef AES_CTRL_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

`ifdef AES_CTRL_TIMEOUT_EN
  logic unused_cfg;
  assign unused_cfg = ^ctrl_sync[7:4];
`else
  // Without the watchdog the timeout limit has no effect.
  logic unused_cfg;
  assign unused_cfg = ^{ctrl_sync[7:4], (TIMEOUT_CYCLES == 0)};
`endif

  assign core_start   = start_q;
  assign core_decrypt = decrypt_q;
  assign core_abort   = abort_q;
  assign irq          = irq_q;
  assign dbg_state    = state_q;
  assign status_out   = {op_count_q[3:0], decrypt_q, tmo_q, done_q, busy_q};

endmodule
